// File: rtl/spectrum_frame_sink.sv
// spectrum_frame_sink: accepts FFT output beats, computes per-bin power
// (re^2 + im^2) through a two-stage pipeline and stores it into a ping-pong
// pair of 512x32 banks. Completed frames are published by swapping banks;
// short/long frames are discarded and flagged.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   frame_size            - 128/256/512 (anything else means 512), latched on beat 0
//   din_re, din_im        - signed FFT sample
//   din_valid, din_last   - beat qualifier and end-of-frame marker
//   hold                  - reader lock; blocks bank swap (frame becomes overrun)
//   rd_en, rd_addr        - read strobe and bin index into the read bank
//   rd_data               - registered bin power, 1-cycle latency
//   frame_ready           - pulse when a new frame is published
//   frame_err             - pulse on a short or long frame
//   overrun               - pulse when a complete frame is dropped due to hold
//   frame_len             - length of the frame in the read bank
//   frame_count           - wrapping count of published frames
module spectrum_frame_sink (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         frame_size,
  input  logic signed [15:0] din_re,
  input  logic signed [15:0] din_im,
  input  logic               din_valid,
  input  logic               din_last,
  input  logic               hold,
  input  logic               rd_en,
  input  logic [8:0]         rd_addr,
  output logic [31:0]        rd_data,
  output logic               frame_ready,
  output logic               frame_err,
  output logic               overrun,
  output logic [9:0]         frame_len,
  output logic [15:0]        frame_count
);

  localparam int unsigned PW    = 32;
  localparam int unsigned AW    = 9;
  localparam int unsigned LW    = 10;
  localparam int unsigned CW    = 16;
  localparam int unsigned DEPTH = 2 * (1 << AW);

  typedef enum logic {FILL, DROP} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   idx, idx_nx;
  logic [LW-1:0]   len_lat, size_norm, len_cur;
  logic            is_end, wr_beat, done_beat, err_beat;

  logic signed [PW-1:0] re_x, im_x;

  logic            s1_valid, s1_done;
  logic [AW-1:0]   s1_addr;
  logic [LW-1:0]   s1_len;
  logic [PW-1:0]   s1_pre, s1_pim;

  logic            s2_valid, s2_done;
  logic [AW-1:0]   s2_addr;
  logic [LW-1:0]   s2_len;
  logic [PW-1:0]   s2_sum;

  logic            rd_bank;
  logic [PW-1:0]   mem [DEPTH];

  // Normalise the requested frame length
  always_comb begin
    size_norm = LW'(512);
    case (frame_size)
      LW'(128): size_norm = LW'(128);
      LW'(256): size_norm = LW'(256);
      default:  size_norm = LW'(512);
    endcase
  end

  // Beat 0 uses the live frame_size; later beats use the latched length
  assign len_cur = (idx == '0) ? size_norm : len_lat;
  assign is_end  = ({1'b0, idx} == (len_cur - LW'(1)));

  assign re_x = PW'(din_re);
  assign im_x = PW'(din_im);

  // Framing FSM: next state and per-beat decisions
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    wr_beat   = 1'b0;
    done_beat = 1'b0;
    err_beat  = 1'b0;
    case (state)
      FILL: begin
        if (din_valid) begin
          if (is_end) begin
            if (din_last) begin
              wr_beat   = 1'b1;
              done_beat = 1'b1;
              idx_nx    = '0;
            end else begin
              err_beat  = 1'b1;
              idx_nx    = '0;
              state_nx  = DROP;
            end
          end else if (din_last) begin
            err_beat = 1'b1;
            idx_nx   = '0;
          end else begin
            wr_beat = 1'b1;
            idx_nx  = idx + AW'(1);
          end
        end
      end
      DROP: begin
        idx_nx = '0;
        if (din_valid && din_last) state_nx = FILL;
      end
      default: begin
        state_nx = FILL;
        idx_nx   = '0;
      end
    endcase
  end

  // FSM state, beat index and frame-length latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FILL;
      idx     <= '0;
      len_lat <= LW'(512);
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (state == FILL && din_valid && idx == '0) len_lat <= size_norm;
    end
  end

  // Power pipeline: stage 1 products, stage 2 sum
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_done  <= 1'b0;
      s2_valid <= 1'b0;
      s2_done  <= 1'b0;
    end else begin
      s1_valid <= wr_beat;
      s1_done  <= done_beat;
      s2_valid <= s1_valid;
      s2_done  <= s1_valid & s1_done;
    end
  end

  always_ff @(posedge clk) begin
    s1_pre  <= PW'(re_x * re_x);
    s1_pim  <= PW'(im_x * im_x);
    s1_addr <= idx;
    s1_len  <= len_cur;
    s2_sum  <= s1_pre + s1_pim;
    s2_addr <= s1_addr;
    s2_len  <= s1_len;
  end

  // Write bank is the one not being read; a same-cycle swap redirects
  // subsequent in-flight writes to the new write bank
  always_ff @(posedge clk) begin
    if (!reset && s2_valid) mem[{~rd_bank, s2_addr}] <= s2_sum;
  end

  // Completion: publish (swap) or flag overrun, plus event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank     <= 1'b0;
      frame_len   <= '0;
      frame_count <= '0;
      frame_ready <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= err_beat;
      if (s2_valid && s2_done) begin
        if (!hold) begin
          rd_bank     <= ~rd_bank;
          frame_len   <= s2_len;
          frame_count <= frame_count + CW'(1);
          frame_ready <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  // Read port; uses the pre-swap bank when a swap coincides with rd_en
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

// File: doc/spectrum_frame_sink.md
SPECTRUM_FRAME_SINK -- requirements
Module: spectrum_frame_sink

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- frame_size  input  10  frame length: 128, 256 or 512; any other value is treated as 512.
- din_re  input  16  signed FFT real output.
- din_im  input  16  signed FFT imaginary output.
- din_valid  input  1  beat qualifier; there is no backpressure, so every valid beat is consumed.
- din_last  input  1  final beat of an FFT frame, qualified by din_valid.
- hold  input  1  reader lock; while high the read bank SHALL NOT swap.
- rd_en  input  1  read strobe.
- rd_addr  input  9  bin index into the read bank.
- rd_data  output  32  power of the addressed bin in the read bank.
- frame_ready  output  1  one-cycle pulse when a new frame becomes readable.
- frame_err  output  1  one-cycle pulse on a framing error.
- overrun  output  1  one-cycle pulse when a complete frame is discarded because hold is high.
- frame_len  output  10  length of the frame in the read bank.
- frame_count  output  16  count of frames published, wrapping.

Function
REQ-002 SHALL hold two 512x32 banks (ping-pong): one write bank, one read bank.
REQ-003 SHALL compute power = re*re + im*im as 32-bit unsigned.
- Worst case is 2*(-32768)^2 = 2^31, which fits; there is no saturation.
REQ-004 SHALL pipeline power in two registered stages.
- Stage 1 registers both products.
- Stage 2 registers the sum and writes it to the write bank.
- The write therefore lands 2 cycles after the beat is accepted.
REQ-005 SHALL latch the normalised frame_size on beat index 0 of each frame.
- Changes to frame_size mid-frame SHALL be ignored until the next frame starts.
REQ-006 SHALL implement states FILL and DROP; the reset state is FILL with beat index 0.
REQ-007 In FILL, on a valid beat at index i < L-1 with din_last=0: write bin i and increment the index.
REQ-008 In FILL, on a valid beat at index L-1 with din_last=1: the frame is complete.
- The beat is written, the index returns to 0 and the state remains FILL.
REQ-009 In FILL, on din_last=1 at index < L-1 (short frame): pulse frame_err.
- Discard the partial frame, set index to 0 and remain in FILL.
REQ-010 In FILL, on the beat at index L-1 with din_last=0 (long frame): pulse frame_err.
- Discard the frame and enter DROP.
REQ-011 In DROP, ignore beats until a valid beat with din_last=1, then enter FILL with index 0.
- No error pulse is repeated.
REQ-012 Completion event: when the final beat's write retires (2 cycles after acceptance), one of two outcomes SHALL apply:
- hold=0: swap banks, set frame_len to L, increment frame_count, and pulse frame_ready in that same cycle.
- hold=1: pulse overrun, do not swap, and keep frame_len and frame_count unchanged.
REQ-013 A discarded frame SHALL NEVER cause a swap, frame_ready or overrun.
- Bins already written to the write bank SHALL be overwritten by the next frame.
REQ-014 Back-to-back frames with no idle cycle SHALL be accepted.
- Beat 0 of frame N+1 may coincide with the write or swap of frame N.
- A swap SHALL redirect in-flight pipeline writes to the new write bank.
REQ-015 Read port:
- rd_data SHALL be registered, with 1-cycle latency from rd_en, taken from the read bank.
- When rd_en=0, rd_data SHALL hold its previous value.
REQ-016 Read bank contents for addresses >= frame_len are undefined.
- A swap in the same cycle as rd_en SHALL return data from the pre-swap read bank.
REQ-017 frame_ready, frame_err and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-018 While reset=1, SHALL hold the outputs as follows:
- state FILL, beat index 0, pipeline valid bits cleared;
- read bank = bank 0;
- frame_len = 0 and frame_count = 0;
- frame_ready, frame_err and overrun = 0;
- rd_data = 0.
REQ-019 Reset mid-frame SHALL discard in-flight beats and pipeline contents with no completion event.
- Memory contents need not be cleared.

Verification
REQ-020 SHALL be verified by these directed scenarios:
- frame_size=128; 128 beats with re=3, im=4, last on beat 127, hold=0 -> frame_ready 2 cycles after the last beat, frame_len=128, frame_count=1, reading bins 0..127 returns 25.
- frame_size=512; re=-32768, im=-32768 on all beats -> every bin reads 0x80000000.
- frame_size=256; last at beat 99 -> frame_err pulse, no frame_ready, frame_count unchanged; a following clean 256-beat frame publishes normally.
- frame_size=128; 130 beats with last only on beat 129 -> frame_err at beat 127, DROP until beat 129, then the next clean frame publishes.
- hold=1 across a complete frame -> overrun pulse, read bank data unchanged; release hold, then the next frame -> frame_ready.
- Two back-to-back 128-point frames (bins = i, then bins = 2i) -> two frame_ready pulses 128 cycles apart, the final read bank holds the 2i pattern, and assert reset mid-third-frame -> frame_count=0, no pulses.
